// File: rtl/matrix_mac_engine.sv
// Sequential N x N unsigned matrix multiplier: A/B operand stores, one MAC per cycle,
// optional C += A*B accumulation, and saturate/wrap overflow handling with a sticky flag.
module matrix_mac_engine #(
    parameter int N    = 4,
    parameter int DW   = 8,
    parameter int ACCW = 32,
    parameter bit SAT  = 1'b0,
    localparam int AW  = $clog2(N * N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            wr_en_i,
    input  logic            wr_sel_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic            start_i,
    input  logic            acc_mode_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            ovf_o,
    input  logic [AW-1:0]   rd_addr_i,
    output logic [ACCW-1:0] rd_data_o
);

    localparam int NN = N * N;
    localparam int IW = $clog2(N);
    localparam int PW = 2 * DW + $clog2(N) + 1;
    localparam int RW = ((PW > ACCW) ? PW : ACCW) + 1;

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_e;
    state_e state_q, state_d;

    logic [DW-1:0]   a_q [NN];
    logic [DW-1:0]   b_q [NN];
    logic [ACCW-1:0] c_q [NN];
    logic [IW-1:0]   i_q, j_q, k_q;
    logic [PW-1:0]   acc_q;
    logic            accm_q, ovf_q;
    logic [ACCW-1:0] rd_q;

    logic [AW-1:0]   a_idx, b_idx, c_idx;
    logic [2*DW-1:0] prod;
    logic [RW-1:0]   r;
    logic            r_ovf;
    logic [ACCW-1:0] r_wr;
    logic            k_last, last_ele, wr_ok, rd_ok;

    always_comb begin
        a_idx    = AW'(i_q) * AW'(N) + AW'(k_q);
        b_idx    = AW'(k_q) * AW'(N) + AW'(j_q);
        c_idx    = AW'(i_q) * AW'(N) + AW'(j_q);
        prod     = (2*DW)'(a_q[a_idx]) * (2*DW)'(b_q[b_idx]);
        // r is wide enough that the old C plus a full dot product can never wrap
        r        = RW'(acc_q) + (accm_q ? RW'(c_q[c_idx]) : RW'(0));
        r_ovf    = |r[RW-1:ACCW];
        r_wr     = (r_ovf && SAT) ? '1 : r[ACCW-1:0];
        k_last   = (k_q == IW'(N - 1));
        last_ele = (i_q == IW'(N - 1)) && (j_q == IW'(N - 1));
        wr_ok    = wr_en_i && (state_q == IDLE || state_q == DONE) &&
                   ({1'b0, wr_addr_i} < (AW+1)'(NN));
        rd_ok    = ({1'b0, rd_addr_i} < (AW+1)'(NN));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = MAC;
            MAC:     if (k_last) state_d = WB;
            WB:      state_d = last_ele ? DONE : MAC;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == MAC) || (state_q == WB);
        done_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc_q  <= '0;
            accm_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    accm_q <= acc_mode_i;
                    ovf_q  <= 1'b0;
                    i_q    <= '0;
                    j_q    <= '0;
                    k_q    <= '0;
                    acc_q  <= '0;
                end
                MAC: begin
                    acc_q <= acc_q + PW'(prod);
                    if (!k_last) k_q <= k_q + IW'(1);
                end
                WB: begin
                    if (r_ovf) ovf_q <= 1'b1;
                    acc_q <= '0;
                    k_q   <= '0;
                    if (j_q == IW'(N - 1)) begin
                        j_q <= '0;
                        i_q <= last_ele ? '0 : i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is flop-based so that reset can clear every element at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NN; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                c_q[e] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr_ok && !wr_sel_i) a_q[wr_addr_i] <= wr_data_i;
            if (wr_ok &&  wr_sel_i) b_q[wr_addr_i] <= wr_data_i;
            if (state_q == WB) c_q[c_idx] <= r_wr;
            rd_q <= rd_ok ? c_q[rd_addr_i] : '0;
        end
    end

    assign ovf_o     = ovf_q;
    assign rd_data_o = rd_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine: three builds (N=4 wrap/32b, N=2 sat/16b, N=3 wrap/16b)
// checked against a plain matrix-product reference model.
module tb_matrix_mac_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  st = '0, we = '0;
    logic        wsel = 1'b0, am = 1'b0, rd_req = 1'b0, rd_live = 1'b0;
    logic [3:0]  waddr = '0, raddr = '0;
    logic [7:0]  wdata = '0;
    logic [2:0]  bsy, dn, ov;
    logic [31:0] rd0;
    logic [15:0] rd1, rd2;
    int          cyc = 0;
    int          checks = 0, errors = 0;
    int          bcnt [3];

    typedef struct { int d; int a; longint v; } rd_t;
    typedef struct { int d; int cyc; bit ovf; } dn_t;
    rd_t rdq [$];
    dn_t dnq [$];

    longint ma [3][25];
    longint mb [3][25];
    longint mc [3][25];

    matrix_mac_engine #(.N(4), .DW(8), .ACCW(32), .SAT(1'b0)) u_m4 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(we[0]), .wr_sel_i(wsel), .wr_addr_i(waddr),
        .wr_data_i(wdata), .start_i(st[0]), .acc_mode_i(am), .busy_o(bsy[0]), .done_o(dn[0]),
        .ovf_o(ov[0]), .rd_addr_i(raddr), .rd_data_o(rd0));

    matrix_mac_engine #(.N(2), .DW(8), .ACCW(16), .SAT(1'b1)) u_s2 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(we[1]), .wr_sel_i(wsel), .wr_addr_i(waddr[1:0]),
        .wr_data_i(wdata), .start_i(st[1]), .acc_mode_i(am), .busy_o(bsy[1]), .done_o(dn[1]),
        .ovf_o(ov[1]), .rd_addr_i(raddr[1:0]), .rd_data_o(rd1));

    matrix_mac_engine #(.N(3), .DW(8), .ACCW(16), .SAT(1'b0)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(we[2]), .wr_sel_i(wsel), .wr_addr_i(waddr),
        .wr_data_i(wdata), .start_i(st[2]), .acc_mode_i(am), .busy_o(bsy[2]), .done_o(dn[2]),
        .ovf_o(ov[2]), .rd_addr_i(raddr), .rd_data_o(rd2));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_live <= rd_req;
    end

    function automatic int nof(int d);
        return (d == 0) ? 4 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic int accw(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic longint rdv(int d);
        return (d == 0) ? longint'(rd0) : ((d == 1) ? longint'(rd1) : longint'(rd2));
    endfunction

    // Reference: C = A*B (+ C), clamp or wrap to ACCW; returns whether any element overflowed
    function automatic bit model_run(int d, bit a);
        int     n = nof(d);
        longint mx = (longint'(1) << accw(d)) - 1;
        longint r;
        bit     o = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                r = 0;
                for (int k = 0; k < n; k++) r += ma[d][i*n+k] * mb[d][k*n+j];
                if (a) r += mc[d][i*n+j];
                if (r > mx) begin
                    o = 1'b1;
                    r = (d == 1) ? mx : (r & mx);
                end
                mc[d][i*n+j] = r;
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int d, input bit s, input int a, input int v, input bit upd);
        we[d] = 1'b1;
        wsel  = s;
        waddr = 4'(a);
        wdata = 8'(v);
        step();
        we[d] = 1'b0;
        if (upd && a < nof(d) * nof(d)) begin
            if (s) mb[d][a] = v;
            else   ma[d][a] = v;
        end
    endtask

    // kind: 0 constant, 1 random, 2 identity, 3 element index + 1
    task automatic fill(input int d, input bit s, input int kind, input int val);
        int n = nof(d);
        int v;
        for (int e = 0; e < n * n; e++) begin
            case (kind)
                0:       v = val;
                1:       v = int'($urandom_range(0, 255));
                2:       v = (e / n == e % n) ? 1 : 0;
                default: v = e + 1;
            endcase
            wr(d, s, e, v, 1'b1);
        end
    endtask

    task automatic go(input logic [2:0] mask, input bit a);
        dn_t x;
        am = a;
        st = mask;
        step();
        st = '0;
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                x.d   = d;
                x.cyc = cyc + nof(d) * nof(d) * (nof(d) + 1);
                x.ovf = model_run(d, a);
                dnq.push_back(x);
            end
        end
    endtask

    task automatic wait_all();
        int t = 0;
        while (dnq.size() != 0 && t < 400) begin
            step();
            t++;
        end
        if (dnq.size() != 0) begin
            chk("done_timeout_pending", dnq.size(), 0);
            dnq.delete();
        end
    endtask

    task automatic rd(input int d, input int a);
        rd_t x;
        raddr  = 4'(a);
        rd_req = 1'b1;
        x.d = d;
        x.a = a;
        x.v = (a < nof(d) * nof(d)) ? mc[d][a] : 0;
        rdq.push_back(x);
        step();
        rd_req = 1'b0;
    endtask

    task automatic sweep(input int d, input int hi);
        for (int a = 0; a < hi; a++) rd(d, a);
        step();
    endtask

    // Monitor: pops read responses and done pulses independently of the stimulus
    always @(negedge clk) begin
        rd_t x;
        int  idx;
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) bcnt[d] = 0;
        end else begin
            if (rd_live) begin
                if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    x = rdq.pop_front();
                    chk($sformatf("rd_d%0d_a%0d", x.d, x.a), rdv(x.d), x.v);
                end
            end
            for (int d = 0; d < 3; d++) begin
                if (bsy[d]) bcnt[d]++;
                if (dn[d]) begin
                    idx = -1;
                    for (int q = 0; q < dnq.size(); q++)
                        if (dnq[q].d == d && idx < 0) idx = q;
                    if (idx < 0) chk($sformatf("done_unexpected_d%0d", d), 1, 0);
                    else begin
                        chk($sformatf("done_cycle_d%0d", d), cyc, dnq[idx].cyc);
                        chk($sformatf("ovf_d%0d", d), ov[d], dnq[idx].ovf);
                        chk($sformatf("busy_len_d%0d", d), bcnt[d], nof(d) * nof(d) * (nof(d) + 1));
                        dnq.delete(idx);
                    end
                    bcnt[d] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", bsy, 0);
        chk("rst_done", dn, 0);
        chk("rst_ovf", ov, 0);
        chk("rst_rd0", rd0, 0);
        step();
        step();
        rst_n = 1'b1;

        // Identity times index pattern
        fill(0, 0, 2, 0);
        fill(0, 1, 3, 0);
        go(3'b001, 1'b0);
        wait_all();
        sweep(0, 16);

        // All-ones times all-twos, then accumulate on top
        fill(0, 0, 0, 1);
        fill(0, 1, 0, 2);
        go(3'b001, 1'b0);
        wait_all();
        sweep(0, 16);
        go(3'b001, 1'b1);
        wait_all();
        sweep(0, 16);

        // Start and A[0] write mid-run must be ignored; the rerun proves A[0] kept its value
        fill(0, 0, 2, 0);
        fill(0, 1, 1, 0);
        go(3'b001, 1'b0);
        repeat (8) step();
        st[0] = 1'b1; we[0] = 1'b1; wsel = 1'b0; waddr = 4'd0; wdata = 8'd99;
        step();
        st[0] = 1'b0; we[0] = 1'b0;
        wait_all();
        go(3'b001, 1'b0);
        wait_all();
        sweep(0, 16);

        // Overflow: saturating N=2 and wrapping N=3 with all-255 operands
        fill(1, 0, 0, 255);
        fill(1, 1, 0, 255);
        fill(2, 0, 0, 255);
        fill(2, 1, 0, 255);
        wr(2, 0, 12, 7, 1'b1);
        go(3'b110, 1'b0);
        wait_all();
        sweep(1, 4);
        sweep(2, 16);
        go(3'b110, 1'b1);
        wait_all();
        sweep(1, 4);
        sweep(2, 16);

        // Random operands on all builds
        repeat (3) begin
            for (int d = 0; d < 3; d++) begin
                fill(d, 0, 1, 0);
                fill(d, 1, 1, 0);
            end
            go(3'b111, 1'($urandom_range(0, 1)));
            wait_all();
            sweep(0, 16);
            sweep(1, 4);
            sweep(2, 9);
        end

        // Async reset in the middle of a run
        fill(0, 0, 1, 0);
        go(3'b001, 1'b0);
        repeat (36) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bsy, 0);
        chk("midrst_done", dn, 0);
        chk("midrst_ovf", ov, 0);
        chk("midrst_rd0", rd0, 0);
        chk("midrst_rd1", rd1, 0);
        chk("midrst_rd2", rd2, 0);
        for (int d = 0; d < 3; d++)
            for (int e = 0; e < 25; e++) begin
                ma[d][e] = 0; mb[d][e] = 0; mc[d][e] = 0;
            end
        dnq.delete();
        step();
        step();
        rst_n = 1'b1;
        sweep(0, 16);
        sweep(2, 16);
        fill(0, 0, 1, 0);
        fill(0, 1, 1, 0);
        go(3'b001, 1'b0);
        wait_all();
        sweep(0, 16);

        repeat (3) step();
        chk("dn_queue_empty", dnq.size(), 0);
        chk("rd_queue_empty", rdq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
